debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent inputs (>=1).
REQ-002 SHALL have parameter STABLE_CYCLES, default 8, consecutive disagreeing cycles needed to accept a new level (>=2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth (>=2).
REQ-004 SHALL have parameters REPEAT_DELAY, default 200, and REPEAT_PERIOD, default 50, auto-repeat timing in cycles (>=1 each).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 btn_in  input  CHANNELS  raw asynchronous button/encoder contacts.
REQ-008 btn_level  output  CHANNELS  debounced level per channel.
REQ-009 btn_press  output  CHANNELS  one-cycle pulse on accepted 0->1.
REQ-010 btn_release  output  CHANNELS  one-cycle pulse on accepted 1->0.
REQ-011 btn_repeat  output  CHANNELS  one-cycle auto-repeat pulses while held.

Function
REQ-012 Each channel SHALL pass btn_in through SYNC_STAGES flops before any other logic.
REQ-013 Per channel, counter width SHALL be clog2(STABLE_CYCLES+1); it SHALL never wrap.
REQ-014 Synced value equal to btn_level: counter SHALL clear to 0 that cycle.
REQ-015 Synced value differing: counter SHALL increment; on the cycle it would reach STABLE_CYCLES, btn_level SHALL toggle and counter SHALL clear.
REQ-016 A clean step held steady SHALL change btn_level exactly SYNC_STAGES+STABLE_CYCLES rising edges after the first edge sampling the new value.
REQ-017 Any disagreement run shorter than STABLE_CYCLES SHALL produce no level change and no pulse.
REQ-018 btn_press/btn_release SHALL be registered and asserted for exactly the one cycle in which btn_level first shows the new value.
REQ-019 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-020 btn_press and btn_release SHALL never be high together on one channel.

Reset
REQ-021 While rst is high at a rising edge: synchronisers, counters, repeat timers and all outputs SHALL be 0 after that edge.
REQ-022 Reset mid-count SHALL discard partial progress; counting restarts from 0 on the first edge with rst low.
REQ-023 An input held high through reset SHALL yield btn_press SYNC_STAGES+STABLE_CYCLES edges after rst deasserts; no pulse during or directly after reset.

Configuration
REQ-024 Macro DEBOUNCE_REPEAT_EN defined: per-channel repeat timer SHALL emit btn_repeat REPEAT_DELAY cycles after btn_press, then every REPEAT_PERIOD cycles while btn_level stays 1.
REQ-025 Repeat timer SHALL clear on btn_release and on rst; no btn_repeat in the cycle of btn_release.
REQ-026 Macro undefined: btn_repeat SHALL be tied 0, no repeat timer logic SHALL exist, REPEAT_* parameters ignored.

Structure
REQ-027 Package debounce_pkg SHALL hold default parameter constants and the counter-width function.
REQ-028 Sub-module debounce_channel SHALL implement one channel (sync, counter, level, pulses, repeat); debounce_bank SHALL instantiate CHANNELS copies via generate.

Verification (CHANNELS=4, STABLE_CYCLES=8, SYNC_STAGES=2)
REQ-029 btn_in[0] 0->1 at edge 10, held -> btn_level[0]=1 and btn_press[0]=1 at edge 20 only; other channels stay 0.
REQ-030 btn_in[1] high 7 cycles then low -> btn_level[1] stays 0; no press/release on any channel.
REQ-031 btn_in[2] toggles every 3 cycles for 30 cycles then stays 1 -> exactly one btn_press[2], 10 edges after final transition.
REQ-032 btn_in[3] high, rst pulsed 1 cycle at counter=5 -> btn_level[3]=0 throughout; btn_press[3] 10 edges after rst deasserts.
REQ-033 btn_in[0] released after REQ-029 -> single btn_release[0] 10 edges later; btn_press[0] never concurrent.
REQ-034 DEBOUNCE_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, channel held 48 cycles past btn_press -> btn_repeat at offsets 20,25,30,35,40,45 only; none without macro.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared defaults, per-channel event record and counter-width helper for debounce_bank.
// The optional auto-repeat feature is enabled by defining DEBOUNCE_REPEAT_EN.
package debounce_pkg;

  localparam int unsigned DefChannels     = 4;
  localparam int unsigned DefStableCycles = 8;
  localparam int unsigned DefSyncStages   = 2;
  localparam int unsigned DefRepeatDelay  = 200;
  localparam int unsigned DefRepeatPeriod = 50;

  typedef struct packed {
    logic lvl;
    logic press;
    logic rel;
    logic rpt;
  } chan_evt_t;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stability counter, level, edge pulses and
// (with DEBOUNCE_REPEAT_EN defined) an auto-repeat timer.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned SYNC_STAGES   = DefSyncStages
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD = DefRepeatPeriod
`endif
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_btn,
  output chan_evt_t o_evt
);

  localparam int unsigned CntW = cnt_width(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CntW-1:0]        r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   w_synced;
  logic                   w_differ;
  logic                   w_accept;
  logic                   w_rpt;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_differ = w_synced ^ r_level;
  // Counter holds STABLE_CYCLES for one cycle before the level flips, so the
  // step-to-level latency is SYNC_STAGES + STABLE_CYCLES edges.
  assign w_accept = w_differ && (r_cnt == CntW'(STABLE_CYCLES));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_accept & ~r_level;
      r_release <= w_accept & r_level;
      if (w_accept) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + CntW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = cnt_width(RptMax);

  logic [RptW-1:0] r_rpt_cnt;
  logic            r_rpt_periodic;
  logic            r_rpt;
  logic [RptW-1:0] w_rpt_target;

  assign w_rpt_target = r_rpt_periodic ? RptW'(REPEAT_PERIOD - 1) : RptW'(REPEAT_DELAY - 1);

  // Any level change (press or release) restarts the timer; release wins over a due repeat.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_accept || !r_level) begin
      r_rpt_cnt      <= '0;
      r_rpt_periodic <= 1'b0;
      r_rpt          <= 1'b0;
    end else if (r_rpt_cnt == w_rpt_target) begin
      r_rpt_cnt      <= '0;
      r_rpt_periodic <= 1'b1;
      r_rpt          <= 1'b1;
    end else begin
      r_rpt_cnt <= r_rpt_cnt + RptW'(1);
      r_rpt     <= 1'b0;
    end
  end

  assign w_rpt = r_rpt;
`else
  assign w_rpt = 1'b0;
`endif

  assign o_evt.lvl   = r_level;
  assign o_evt.press = r_press;
  assign o_evt.rel   = r_release;
  assign o_evt.rpt   = w_rpt;

endmodule

// File: rtl/debounce_bank.sv
// Bank of CHANNELS independent debouncers sharing one clock and synchronous reset.
// Define DEBOUNCE_REPEAT_EN to enable per-channel auto-repeat; otherwise btn_repeat is 0.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS      = DefChannels,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned SYNC_STAGES   = DefSyncStages,
  parameter int unsigned REPEAT_DELAY  = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD = DefRepeatPeriod
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat
);

  if (CHANNELS < 1 || STABLE_CYCLES < 2 || SYNC_STAGES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
    $error("debounce_bank: parameter out of range");
  end

  chan_evt_t w_evt [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
`ifdef DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_chan (
      .i_clk (clk),
      .i_rst (rst),
      .i_btn (btn_in[g]),
      .o_evt (w_evt[g])
    );

    assign btn_level[g]   = w_evt[g].lvl;
    assign btn_press[g]   = w_evt[g].press;
    assign btn_release[g] = w_evt[g].rel;
    assign btn_repeat[g]  = w_evt[g].rpt;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (4 channels, 8 stable cycles, 2 sync stages).
// Repeat expectations follow DEBOUNCE_REPEAT_EN as defined for the build.
module tb_debounce_bank;

  localparam int unsigned Ch        = 4;
  localparam int unsigned Stable    = 8;
  localparam int unsigned Sync      = 2;
  localparam int unsigned RptDelay  = 20;
  localparam int unsigned RptPeriod = 5;
  localparam int unsigned Lat       = Sync + Stable;
  localparam int unsigned NVec      = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic [Ch-1:0] btn_in;
  logic [Ch-1:0] btn_level;
  logic [Ch-1:0] btn_press;
  logic [Ch-1:0] btn_release;
  logic [Ch-1:0] btn_repeat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .CHANNELS      (Ch),
    .STABLE_CYCLES (Stable),
    .SYNC_STAGES   (Sync),
    .REPEAT_DELAY  (RptDelay),
    .REPEAT_PERIOD (RptPeriod)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  typedef struct {
    logic [Ch-1:0] in;
    logic [Ch-1:0] lvl;
    logic [Ch-1:0] prs;
    logic [Ch-1:0] rel;
    logic [Ch-1:0] rpt;
  } vec_t;

  vec_t vecs [NVec];

`ifdef DEBOUNCE_REPEAT_EN
  localparam bit RptOn = 1'b1;
`else
  localparam bit RptOn = 1'b0;
`endif

  task automatic chk(input string name, input int idx, input logic [Ch-1:0] act,
                     input logic [Ch-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0d got %b want %b", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name, input int idx);
    chk({name, "_level"}, idx, btn_level, '0);
    chk({name, "_press"}, idx, btn_press, '0);
    chk({name, "_release"}, idx, btn_release, '0);
    chk({name, "_repeat"}, idx, btn_repeat, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk_idle("reset", 0);
    rst = 1'b0;
  endtask

  int n_press;
  logic exp_rpt;

  initial begin
    rst    = 1'b1;
    btn_in = '0;

    // ch0 clean press/release, ch1 7-cycle glitch, ch2/ch3 simultaneous press/release.
    for (int i = 0; i < NVec; i++) begin
      vecs[i].in     = '0;
      vecs[i].lvl    = '0;
      vecs[i].prs    = '0;
      vecs[i].rel    = '0;
      vecs[i].rpt    = '0;
      vecs[i].in[0]  = (i < 30);
      vecs[i].in[1]  = (i >= 2 && i <= 8);
      vecs[i].in[2]  = (i >= 15 && i < 35);
      vecs[i].in[3]  = (i >= 15 && i < 35);
      vecs[i].lvl[0] = (i >= 10 && i < 40);
      vecs[i].prs[0] = (i == 10);
      vecs[i].rel[0] = (i == 40);
      vecs[i].lvl[2] = (i >= 25 && i < 45);
      vecs[i].lvl[3] = (i >= 25 && i < 45);
      vecs[i].prs[2] = (i == 25);
      vecs[i].prs[3] = (i == 25);
      vecs[i].rel[2] = (i == 45);
      vecs[i].rel[3] = (i == 45);
      // ch0 repeats at press+20, +25; the +30 slot coincides with release and is dropped.
      vecs[i].rpt[0] = RptOn && (i == 30 || i == 35);
    end

    do_reset();

    for (int i = 0; i < NVec; i++) begin
      btn_in = vecs[i].in;
      tick();
      chk("tbl_level", i, btn_level, vecs[i].lvl);
      chk("tbl_press", i, btn_press, vecs[i].prs);
      chk("tbl_release", i, btn_release, vecs[i].rel);
      chk("tbl_repeat", i, btn_repeat, vecs[i].rpt);
      chk("tbl_press_and_release", i, btn_press & btn_release, '0);
    end

    // ch2 bounces in 3-cycle runs for 30 cycles, then settles high.
    do_reset();
    btn_in  = '0;
    n_press = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 3; j++) begin
        btn_in[2] = (k % 2 == 0);
        tick();
        chk("bounce_level", k * 3 + j, btn_level, '0);
        chk("bounce_pulses", k * 3 + j, btn_press | btn_release, '0);
      end
    end
    btn_in[2] = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      tick();
      if (btn_press[2]) n_press++;
      chk("settle_press", c, btn_press, (c == Lat) ? 4'b0100 : 4'b0000);
      chk("settle_level", c, btn_level, (c >= Lat) ? 4'b0100 : 4'b0000);
    end
    chk("settle_press_count", 0, Ch'(n_press), Ch'(1));

    // Reset while a level is high clears everything.
    do_reset();

    // ch3 held high, reset pulsed when its counter reads 5.
    btn_in = 4'b1000;
    for (int c = 0; c <= 6; c++) begin
      tick();
      chk("midrst_pre_level", c, btn_level, '0);
      chk("midrst_pre_press", c, btn_press, '0);
    end
    rst = 1'b1;
    tick();
    chk_idle("midrst", 7);
    rst = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      tick();
      chk("midrst_press", c, btn_press, (c == Lat) ? 4'b1000 : 4'b0000);
      chk("midrst_level", c, btn_level, (c >= Lat) ? 4'b1000 : 4'b0000);
    end

    // Long hold on ch0 for auto-repeat, released so release lands at press+48.
    do_reset();
    btn_in = 4'b0001;
    for (int c = 0; c <= Lat; c++) begin
      tick();
    end
    chk("hold_press", 0, btn_press, 4'b0001);
    for (int o = 1; o <= 48; o++) begin
      if (o == 38) btn_in = '0;
      tick();
      exp_rpt = RptOn && o >= 20 && o < 48 && ((o - 20) % 5 == 0);
      chk("hold_repeat", o, btn_repeat, {3'b000, exp_rpt});
      chk("hold_release", o, btn_release, (o == 48) ? 4'b0001 : 4'b0000);
      chk("hold_press_again", o, btn_press, '0);
    end
    tick();
    chk_idle("hold_after", 49);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
